idu_step_seq: RTL and testbench
===============================

Name: idu_step_seq

Overview:
Parametrised successor of the 16-bit IDU carry-lookahead incrementer. Adds increment/decrement/pass operations, a registered result, a valid/ready handshake, and a block-repeat engine. The repeat engine emits N stepped addresses (LDIR/LDDR-style), counts down a repeat count, and flags the last beat. It sits between the register file and the address bus driver.

Parameters:
WIDTH, 16, datapath and count width in bits (>=4)
GROUP, 4, lookahead group size; must divide WIDTH; sets the carry-chain structure only, never the function

Ports:
CLK  in  1  clock, all state on rising edge
nRESET  in  1  reset, asynchronous, active-low
in_valid  in  1  request present
in_ready  out  1  request accepted this cycle when in_valid&in_ready
in_op  in  2  00 pass, 01 inc, 10 dec, 11 reserved (treated as pass)
in_rep  in  1  1 = repeat mode using in_cnt; 0 = single beat
in_val  in  WIDTH  start value
in_cnt  in  WIDTH  repeat count; 0 means 2^WIDTH beats
abort  in  1  synchronous cancel of the current run
out_valid  out  1  beat present
out_ready  in  1  beat consumed when out_valid&out_ready
out_val  out  WIDTH  stepped value
out_cnt  out  WIDTH  beats remaining after this one
out_carry  out  1  this beat's step wrapped (inc from all-ones, or dec from zero)
out_wrap  out  1  sticky OR of out_carry over the current run
out_last  out  1  final beat of the run
busy  out  1  state RUN

Behaviour:
Reset: while nRESET=0, all outputs are 0, state is IDLE, and internal value/count are 0. Reset mid-run discards the run with no further beats.

States:
- IDLE: in_ready=1; out_valid=0.
- RUN: out_valid=1; in_ready = out_ready & out_last (back-to-back acceptance).

Accept request (in IDLE, or in RUN on the last-beat handshake):
- N = in_rep ? in_cnt : 1.
- Next cycle enters RUN with beat 0: out_val = in_val±1 (pass: in_val), out_cnt = N-1 mod 2^WIDTH, out_carry = wrap of that step, out_wrap = out_carry, out_last = (N==1).
- Latency from accept to first out_valid is 1 cycle.

Beat handshake in RUN:
- If out_last: go to IDLE, unless a new request is accepted in the same cycle, in which case stay in RUN with the new beat 0.
- Otherwise: out_val steps once more, out_cnt decrements, out_carry is recomputed, out_wrap |= out_carry, and out_last = (new out_cnt==0).

Stall: with out_valid=1 and out_ready=0, all outputs hold stable.

Counts and wrap:
- Beat k (k=0..N-1) has out_val = in_val ± (k+1) mod 2^WIDTH.
- in_cnt=0 runs 2^WIDTH beats: out_cnt starts at all-ones and out_last is asserted only when out_cnt reaches 0.

abort:
- Abort in RUN: next cycle goes to IDLE with out_valid=0; any pending beat is dropped, even if out_ready=1 in the same cycle.
- Abort in IDLE: ignored, and blocks acceptance that cycle (in_ready=0).

Arithmetic:
- The step is a group carry-lookahead.
- Inc: group propagate = AND of the group's bits; carry into group g = AND of all lower propagates.
- Dec: same structure on inverted bits.
- out_carry is the carry out of the MSB.
- No ripple chain longer than GROUP bits.

Decomposition:
Shared package idu_pkg holds:
- idu_op_t enum (PASS, INC, DEC, RSVD)
- idu_state_t enum (IDLE, RUN)
- the OP_* encoding constants

Natural sub-module: idu_cla_step. It is a combinational WIDTH/GROUP-parametrised ±1 unit with carry out. It is instantiated twice: once for the value step and once as the count decrementer.

Test Plan:
- Single inc: in_val=16'h00FF, op=inc, rep=0 -> 1 cycle later out_val=16'h0100, out_carry=0, out_last=1, out_cnt=0.
- Wrap: in_val=16'hFFFF, op=inc -> out_val=16'h0000, out_carry=1. Then in_val=16'h0000, op=dec -> out_val=16'hFFFF, out_carry=1.
- Repeat: in_val=16'h1000, op=dec, in_cnt=3, out_ready=1 -> beats 0FFF/0FFE/0FFD with out_cnt 2/1/0, out_last only on the third beat; then a back-to-back new request is accepted in the same cycle.
- Stall and abort: in_cnt=5, out_ready=0 for 4 cycles -> outputs stable. Abort on beat 2 -> out_valid=0 the next cycle, busy=0, no further beats.
- Zero count with WIDTH=4, GROUP=2: in_cnt=0, in_val=4'hE, op=inc -> 16 beats, out_wrap goes to 1 at beat 1 (value 0), out_last on beat 15.
- Reset mid-run: nRESET low asynchronously during beat 1 -> all outputs 0 immediately; after release, in_ready=1.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared types and encodings for the IDU step sequencer and its lookahead step unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package idu_pkg;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        PASS = OP_PASS,
        INC  = OP_INC,
        DEC  = OP_DEC,
        RSVD = OP_RSVD
    } idu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } idu_state_t;

endpackage

// File: rtl/idu_cla_step.sv
// Combinational +1 / -1 unit built as a group carry-lookahead; carry_o is the MSB carry/borrow.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; en_i=0 passes the value through with no carry.
module idu_cla_step #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             en_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o
);

    localparam int NG = WIDTH / GROUP;

    // Decrement is an increment of the inverted operand, inverted back:
    // val-1 == ~(~val + 1). Both directions therefore share one lookahead tree.
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] sum;
    logic [NG-1:0]    gp;

    // Select the operand polarity for the shared incrementer.
    always_comb begin
        x = dec_i ? ~val_i : val_i;
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        // Carry entering each bit of this group; the ripple never spans more than GROUP bits.
        logic [GROUP-1:0] lc;

        assign gp[g] = &x[g*GROUP +: GROUP];

        // Group carry-in is the AND of every lower group propagate, not a chained carry.
        if (g == 0) begin : g_cin0
            assign lc[0] = 1'b1;
        end else begin : g_cinn
            assign lc[0] = &gp[g-1:0];
        end

        for (genvar j = 0; j < GROUP; j++) begin : g_bit
            assign sum[g*GROUP+j] = x[g*GROUP+j] ^ lc[j];
            if (j < GROUP - 1) begin : g_rip
                assign lc[j+1] = lc[j] & x[g*GROUP+j];
            end
        end
    end

    // Undo the operand inversion for decrement and qualify the carry with the enable.
    always_comb begin
        res_o   = en_i ? (dec_i ? ~sum : sum) : val_i;
        carry_o = en_i & (&gp);
    end

endmodule

// File: rtl/idu_step_seq.sv
// Block-repeat address stepper: emits N stepped values (pass/inc/dec), counting down and flagging the last beat.
// Latency: 1 cycle from request accept to first beat; one beat per cycle thereafter.
// Backpressure: out_ready=0 holds every output stable; a new request is taken only in IDLE or on the last-beat handshake.
module idu_step_seq
    import idu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_rep,
    input  logic [WIDTH-1:0] in_val,
    input  logic [WIDTH-1:0] in_cnt,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic [WIDTH-1:0] out_cnt,
    output logic             out_carry,
    output logic             out_wrap,
    output logic             out_last,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    idu_state_t       state_q, state_d;
    idu_op_t          op_q, op_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             wrap_q, wrap_d;
    logic             last_q, last_d;

    logic             accept;
    logic             step_beat;
    idu_op_t          step_op;
    logic [WIDTH-1:0] step_src;
    logic [WIDTH-1:0] step_val;
    logic             step_carry;
    logic [WIDTH-1:0] cnt_src;
    logic [WIDTH-1:0] cnt_dec;
    logic             cnt_borrow_unused;

    assign accept    = in_valid & in_ready;
    // A non-final beat is consumed and the run continues; abort wins over the handshake.
    assign step_beat = (state_q == RUN) & out_ready & ~abort & ~last_q;

    // The same step unit serves both beat 0 (from the request) and later beats (from the held value).
    assign step_op  = accept ? idu_op_t'(in_op) : op_q;
    assign step_src = accept ? in_val : val_q;
    // Beat 0 counts down from N; later beats count down from the held remaining count.
    assign cnt_src  = accept ? (in_rep ? in_cnt : ONE) : cnt_q;

    idu_cla_step #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) u_val_step (
        .val_i   (step_src),
        .en_i    ((step_op == INC) || (step_op == DEC)),
        .dec_i   (step_op == DEC),
        .res_o   (step_val),
        .carry_o (step_carry)
    );

    // Count decrementer; its borrow is meaningless here because in_cnt=0 encodes 2^WIDTH beats.
    idu_cla_step #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) u_cnt_step (
        .val_i   (cnt_src),
        .en_i    (1'b1),
        .dec_i   (1'b1),
        .res_o   (cnt_dec),
        .carry_o (cnt_borrow_unused)
    );

    // State register.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort drops the run; the last beat either ends it or chains straight into a new one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready && last_q) begin
                    state_d = accept ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; abort blocks acceptance in both states, and reset forces everything low.
    always_comb begin
        out_valid = (state_q == RUN);
        busy      = (state_q == RUN);
        in_ready  = 1'b0;
        case (state_q)
            IDLE:    in_ready = nRESET & ~abort;
            RUN:     in_ready = out_ready & last_q & ~abort;
            default: in_ready = 1'b0;
        endcase
    end

    // Beat datapath next-state: load beat 0 on accept, advance on a non-final beat, otherwise hold.
    always_comb begin
        op_d    = op_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        wrap_d  = wrap_q;
        last_d  = last_q;
        if (accept) begin
            op_d    = idu_op_t'(in_op);
            val_d   = step_val;
            cnt_d   = cnt_dec;
            carry_d = step_carry;
            wrap_d  = step_carry;
            last_d  = (cnt_dec == '0);
        end else if (step_beat) begin
            val_d   = step_val;
            cnt_d   = cnt_dec;
            carry_d = step_carry;
            wrap_d  = wrap_q | step_carry;
            last_d  = (cnt_dec == '0);
        end
    end

    // Beat datapath registers.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            op_q    <= PASS;
            val_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            wrap_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            wrap_q  <= wrap_d;
            last_q  <= last_d;
        end
    end

    assign out_val   = val_q;
    assign out_cnt   = cnt_q;
    assign out_carry = carry_q;
    assign out_wrap  = wrap_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_idu_step_seq.sv
module tb_idu_step_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 16-bit / group-4 instance
    logic        a_in_valid, a_in_ready, a_in_rep, a_abort;
    logic        a_out_valid, a_out_ready, a_out_carry, a_out_wrap, a_out_last, a_busy;
    logic [1:0]  a_in_op;
    logic [15:0] a_in_val, a_in_cnt, a_out_val, a_out_cnt;

    // 4-bit / group-2 instance
    logic        b_in_valid, b_in_ready, b_in_rep, b_abort;
    logic        b_out_valid, b_out_ready, b_out_carry, b_out_wrap, b_out_last, b_busy;
    logic [1:0]  b_in_op;
    logic [3:0]  b_in_val, b_in_cnt, b_out_val, b_out_cnt;

    idu_step_seq #(.WIDTH(16), .GROUP(4)) u_dut_a (
        .CLK(clk), .nRESET(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_rep(a_in_rep),
        .in_val(a_in_val), .in_cnt(a_in_cnt), .abort(a_abort),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_val(a_out_val), .out_cnt(a_out_cnt),
        .out_carry(a_out_carry), .out_wrap(a_out_wrap), .out_last(a_out_last), .busy(a_busy)
    );

    idu_step_seq #(.WIDTH(4), .GROUP(2)) u_dut_b (
        .CLK(clk), .nRESET(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_rep(b_in_rep),
        .in_val(b_in_val), .in_cnt(b_in_cnt), .abort(b_abort),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_val(b_out_val), .out_cnt(b_out_cnt),
        .out_carry(b_out_carry), .out_wrap(b_out_wrap), .out_last(b_out_last), .busy(b_busy)
    );

    typedef struct {
        int op;
        bit rep;
        int val;
        int cnt;
    } req_t;

    typedef struct packed {
        logic [15:0] val;
        logic [15:0] cnt;
        logic        carry;
        logic        wrap;
        logic        last;
    } beat_t;

    int total = 0;
    int bad   = 0;

    req_t  req_q[$];
    beat_t exp_q[$];

    // Beat k of a run, straight from the arithmetic rules: value = start +/- (k+1),
    // carry when the value being stepped is all-ones (inc) or zero (dec), wrap = any carry so far.
    function automatic beat_t model_beat(int w, int op, bit rep, int v, int c, int k);
        beat_t b;
        int    mask;
        int    n;
        int    step;
        bit    cy;
        mask = (1 << w) - 1;
        n    = rep ? ((c & mask) == 0 ? (1 << w) : (c & mask)) : 1;
        step = (op == 1) ? 1 : ((op == 2) ? -1 : 0);
        cy   = 1'b0;
        b    = '0;
        for (int j = 0; j <= k; j++) begin
            int prev;
            prev   = (v + step * j) & mask;
            cy     = (op == 1 && prev == mask) || (op == 2 && prev == 0);
            b.wrap = b.wrap | cy;
        end
        b.carry = cy;
        b.val   = 16'((v + step * (k + 1)) & mask);
        b.cnt   = 16'((n - 1 - k) & mask);
        b.last  = (k == n - 1);
        return b;
    endfunction

    function automatic int run_len(int w, bit rep, int c);
        int mask;
        mask = (1 << w) - 1;
        return rep ? ((c & mask) == 0 ? (1 << w) : (c & mask)) : 1;
    endfunction

    // Drives queued requests into instance A, consuming beats with a random ready pattern,
    // checking every cycle's valid/ready and beat contents against the model queue.
    task automatic run_engine(input int ready_pct, input int budget, input string tag);
        int    cyc;
        bit    fire_in, fire_out;
        logic  exp_rdy;
        req_t  r;
        beat_t got;
        cyc = 0;
        while ((req_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            if (req_q.size() != 0) begin
                r          = req_q[0];
                a_in_valid = 1'b1;
                a_in_op    = 2'(r.op);
                a_in_rep   = r.rep;
                a_in_val   = 16'(r.val);
                a_in_cnt   = 16'(r.cnt);
            end else begin
                a_in_valid = 1'b0;
            end
            a_out_ready = ($urandom_range(99) < ready_pct);
            #1;
            total++;
            if (a_out_valid !== (exp_q.size() != 0)) begin
                bad++;
                $display("FAIL %s out_valid: got %b exp %b", tag, a_out_valid, exp_q.size() != 0);
            end
            if (a_out_valid === 1'b1 && exp_q.size() != 0) begin
                got = {a_out_val, a_out_cnt, a_out_carry, a_out_wrap, a_out_last};
                total++;
                if (got !== exp_q[0]) begin
                    bad++;
                    $display("FAIL %s beat: got val=%h cnt=%h c=%b w=%b l=%b exp val=%h cnt=%h c=%b w=%b l=%b",
                             tag, got.val, got.cnt, got.carry, got.wrap, got.last,
                             exp_q[0].val, exp_q[0].cnt, exp_q[0].carry, exp_q[0].wrap, exp_q[0].last);
                end
            end
            exp_rdy = (exp_q.size() == 0) || (a_out_ready && exp_q.size() == 1);
            total++;
            if (a_in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL %s in_ready: got %b exp %b", tag, a_in_ready, exp_rdy);
            end
            fire_out = a_out_valid & a_out_ready;
            fire_in  = a_in_valid & a_in_ready;
            @(posedge clk);
            if (fire_out && exp_q.size() != 0) void'(exp_q.pop_front());
            if (fire_in && req_q.size() != 0) begin
                for (int k = 0; k < run_len(16, r.rep, r.cnt); k++)
                    exp_q.push_back(model_beat(16, r.op, r.rep, r.val, r.cnt, k));
                void'(req_q.pop_front());
            end
            cyc++;
        end
        @(negedge clk);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        #1;
        total++;
        if (cyc >= budget || a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s drain: cycles=%0d out_valid=%b busy=%b exp out_valid=0 busy=0 within %0d",
                     tag, cyc, a_out_valid, a_busy, budget);
        end
        req_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_rep = 0; a_abort = 0; a_out_ready = 0; a_in_op = 0; a_in_val = 0; a_in_cnt = 0;
        b_in_valid = 0; b_in_rep = 0; b_abort = 0; b_out_ready = 0; b_in_op = 0; b_in_val = 0; b_in_cnt = 0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({a_in_ready, a_out_valid, a_out_val, a_out_cnt, a_out_carry, a_out_wrap, a_out_last, a_busy} !== '0) begin
            bad++;
            $display("FAIL reset_a: got rdy=%b vld=%b val=%h cnt=%h busy=%b exp all zero",
                     a_in_ready, a_out_valid, a_out_val, a_out_cnt, a_busy);
        end
        total++;
        if ({b_in_ready, b_out_valid, b_out_val, b_out_cnt, b_out_carry, b_out_wrap, b_out_last, b_busy} !== '0) begin
            bad++;
            $display("FAIL reset_b: got rdy=%b vld=%b val=%h cnt=%h exp all zero",
                     b_in_ready, b_out_valid, b_out_val, b_out_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b busy=%b exp 1 0", a_in_ready, a_busy);
        end
    endtask

    task automatic test_single_inc();
        req_q.push_back('{op: 1, rep: 1'b0, val: 'h00FF, cnt: 'h1234});
        run_engine(100, 50, "single_inc");
    endtask

    task automatic test_wrap();
        req_q.push_back('{op: 1, rep: 1'b0, val: 'hFFFF, cnt: 0});
        req_q.push_back('{op: 2, rep: 1'b0, val: 'h0000, cnt: 0});
        req_q.push_back('{op: 3, rep: 1'b1, val: 'hABCD, cnt: 2});
        run_engine(100, 50, "wrap");
    endtask

    task automatic test_back_to_back();
        req_q.push_back('{op: 2, rep: 1'b1, val: 'h1000, cnt: 3});
        req_q.push_back('{op: 1, rep: 1'b1, val: 'hFFFE, cnt: 4});
        req_q.push_back('{op: 0, rep: 1'b0, val: 'h5A5A, cnt: 7});
        run_engine(100, 100, "back_to_back");
    endtask

    task automatic test_stall_abort();
        beat_t got, exp;
        @(negedge clk);
        a_in_valid = 1; a_in_op = 2'd1; a_in_rep = 1; a_in_val = 16'h2000; a_in_cnt = 16'd5; a_out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            got = {a_out_val, a_out_cnt, a_out_carry, a_out_wrap, a_out_last};
            exp = model_beat(16, 1, 1'b1, 'h2000, 5, 0);
            total++;
            if (a_out_valid !== 1'b1 || got !== exp) begin
                bad++;
                $display("FAIL stall_hold cyc%0d: got vld=%b val=%h cnt=%h exp vld=1 val=%h cnt=%h",
                         i, a_out_valid, got.val, got.cnt, exp.val, exp.cnt);
            end
            @(negedge clk);
        end
        a_out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            got = {a_out_val, a_out_cnt, a_out_carry, a_out_wrap, a_out_last};
            exp = model_beat(16, 1, 1'b1, 'h2000, 5, k);
            total++;
            if (a_out_valid !== 1'b1 || got !== exp) begin
                bad++;
                $display("FAIL stall_beat%0d: got vld=%b val=%h cnt=%h exp vld=1 val=%h cnt=%h",
                         k, a_out_valid, got.val, got.cnt, exp.val, exp.cnt);
            end
            if (k < 2) @(negedge clk);
        end
        a_abort = 1;
        #1;
        total++;
        if (a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_run_ready: got %b exp 0", a_in_ready);
        end
        @(negedge clk);
        a_abort = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
                bad++;
                $display("FAIL abort_idle cyc%0d: got vld=%b busy=%b exp 0 0", i, a_out_valid, a_busy);
            end
            @(negedge clk);
        end
        a_abort = 1; a_in_valid = 1; a_in_rep = 0; a_in_op = 2'd1;
        #1;
        total++;
        if (a_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle_ready: got %b exp 0", a_in_ready);
        end
        @(negedge clk);
        a_abort = 0; a_in_valid = 0; a_out_ready = 0;
        #1;
        total++;
        if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle_noaccept: got busy=%b vld=%b exp 0 0", a_busy, a_out_valid);
        end
    endtask

    task automatic test_zero_count();
        beat_t got, exp;
        @(negedge clk);
        b_in_valid = 1; b_in_op = 2'd1; b_in_rep = 1; b_in_val = 4'hE; b_in_cnt = 4'h0; b_out_ready = 1;
        #1;
        total++;
        if (b_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_cnt_ready: got %b exp 1", b_in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            got = {12'h000, b_out_val, 12'h000, b_out_cnt, b_out_carry, b_out_wrap, b_out_last};
            exp = model_beat(4, 1, 1'b1, 'hE, 0, k);
            total++;
            if (b_out_valid !== 1'b1 || got !== exp) begin
                bad++;
                $display("FAIL zero_cnt_beat%0d: got vld=%b val=%h cnt=%h c=%b w=%b l=%b exp val=%h cnt=%h c=%b w=%b l=%b",
                         k, b_out_valid, got.val, got.cnt, got.carry, got.wrap, got.last,
                         exp.val, exp.cnt, exp.carry, exp.wrap, exp.last);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_cnt_end: got vld=%b busy=%b exp 0 0", b_out_valid, b_busy);
        end
        b_out_ready = 0;
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        a_in_valid = 1; a_in_op = 2'd1; a_in_rep = 1; a_in_val = 16'h0100; a_in_cnt = 16'd5; a_out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_in_ready, a_out_valid, a_out_val, a_out_cnt, a_out_carry, a_out_wrap, a_out_last, a_busy} !== '0) begin
            bad++;
            $display("FAIL reset_midrun: got rdy=%b vld=%b val=%h cnt=%h busy=%b exp all zero",
                     a_in_ready, a_out_valid, a_out_val, a_out_cnt, a_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_midrun_release: got rdy=%b busy=%b vld=%b exp 1 0 0", a_in_ready, a_busy, a_out_valid);
        end
        a_out_ready = 0;
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(4))
                0: v = 'hFFFF;
                1: v = 'h0000;
                2: v = 'hFFFD;
                3: v = 'h0002;
                default: v = int'($urandom_range(16'hFFFF));
            endcase
            req_q.push_back('{op: int'($urandom_range(3)), rep: bit'($urandom_range(1)),
                              val: v, cnt: int'($urandom_range(1, 6))});
        end
        run_engine(60, 3000, "random");
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_wrap();
        test_back_to_back();
        test_stall_abort();
        test_zero_count();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
